// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// State encoding and digit-correction constants.
package bin_to_bcd_seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DIGITS_DEFAULT = 3;

  localparam logic [3:0] BCD_CORRECT_THRESH = 4'd5;
  localparam logic [3:0] BCD_CORRECT_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5..9
// so the following left shift carries correctly into the next digit.
module bcd_digit_adjust
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Correct digits at or above threshold; others pass through.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_CORRECT_THRESH)
      o_digit = i_digit + BCD_CORRECT_ADD;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock.
// Result is held in bcd between conversions; done pulses on update.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int D = DIGITS_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd
);

  localparam int CW = $clog2(N + 1);
  localparam int SW = 4 * D;

  state_t         r_state;
  state_t         w_next_state;
  logic [N-1:0]   r_shift;
  logic [SW-1:0]  r_scratch;
  logic [SW-1:0]  r_bcd;
  logic [CW-1:0]  r_cnt;
  logic           r_done;

  logic [SW-1:0]  w_adj;
  logic [SW-1:0]  w_scratch_nxt;
  logic [N-1:0]   w_shift_nxt;
  logic           w_load;
  logic           w_step;
  logic           w_finish;
  logic           w_unused_msb;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_scratch[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The bit shifted out of the scratch top is always 0 for legal N/D.
  assign w_unused_msb  = w_adj[SW-1];
  assign w_scratch_nxt = {w_adj[SW-2:0], r_shift[N-1]};
  assign w_shift_nxt   = r_shift << 1;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_step = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_finish     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
    endcase
  end

  // Shift datapath, iteration counter, result and done registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_shift   <= bin;
        r_scratch <= '0;
        r_cnt     <= CW'(N);
      end else if (w_step) begin
        r_shift   <= w_shift_nxt;
        r_scratch <= w_scratch_nxt;
        r_cnt     <= r_cnt - 1'b1;
      end
      if (w_finish)
        r_bcd <= w_scratch_nxt;
    end
  end

  assign busy = (r_state == ST_SHIFT);
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule
